// File: rtl/mk14_loader_pkg.sv
// mk14_loader_pkg: shared types, constants and baud helper for the MK14 serial loader
package mk14_loader_pkg;
  typedef enum logic [2:0] {S_IDLE, S_AHI, S_ALO, S_LEN, S_DATA, S_CSUM} loader_state_t;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  localparam logic [7:0] SYNC_BYTE = 8'h55;
  localparam int TIMEOUT_BITS = 20;
  function automatic int clks_per_bit(input int freq_mhz, input int baud);
    return freq_mhz * 1_000_000 / baud;
  endfunction
endpackage

// File: rtl/mk14_uart_rx.sv
// mk14_uart_rx: 8N1 receiver with 2-FF synchroniser, mid-bit sampling and framing-error strobe
module mk14_uart_rx
  import mk14_loader_pkg::*;
#(
  parameter int CPB = 434
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] data,
  output logic       valid,
  output logic       frame_err
);
  localparam int CW = $clog2(CPB);
  localparam int HALF = CPB / 2;
  logic meta_q, sync_q, prev_q;
  rx_state_t st_q, st_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0] idx_q, idx_d;
  logic [7:0] sh_q, sh_d;
  logic valid_q, valid_d, ferr_q, ferr_d;
  always_comb begin
    st_d = st_q;
    cnt_d = cnt_q + CW'(1);
    idx_d = idx_q;
    sh_d = sh_q;
    valid_d = 1'b0;
    ferr_d = 1'b0;
    case (st_q)
      RX_IDLE: begin
        cnt_d = '0;
        idx_d = '0;
        st_d = (prev_q && !sync_q) ? RX_START : RX_IDLE;
      end
      RX_START: if (cnt_q == CW'(HALF - 1)) begin
        cnt_d = '0;
        st_d = sync_q ? RX_IDLE : RX_DATA;
      end
      RX_DATA: if (cnt_q == CW'(CPB - 1)) begin
        cnt_d = '0;
        sh_d = {sync_q, sh_q[7:1]};
        idx_d = idx_q + 3'd1;
        st_d = (idx_q == 3'd7) ? RX_STOP : RX_DATA;
      end
      RX_STOP: if (cnt_q == CW'(CPB - 1)) begin
        cnt_d = '0;
        st_d = RX_IDLE;
        valid_d = sync_q;
        ferr_d = !sync_q;
      end
      default: st_d = RX_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
      prev_q <= 1'b1;
      st_q <= RX_IDLE;
      cnt_q <= '0;
      idx_q <= '0;
      sh_q <= '0;
      valid_q <= 1'b0;
      ferr_q <= 1'b0;
    end else begin
      meta_q <= rx;
      sync_q <= meta_q;
      prev_q <= sync_q;
      st_q <= st_d;
      cnt_q <= cnt_d;
      idx_q <= idx_d;
      sh_q <= sh_d;
      valid_q <= valid_d;
      ferr_q <= ferr_d;
    end
  end
  assign data = sh_q;
  assign valid = valid_q;
  assign frame_err = ferr_q;
endmodule

// File: rtl/mk14_rx_loader.sv
// mk14_rx_loader: UART frame parser writing payload into MK14 RAM with the core halted.
// Optional inter-byte timeout abort enabled by defining MK14_LOADER_TIMEOUT_EN.
module mk14_rx_loader
  import mk14_loader_pkg::*;
#(
  parameter int CLOCK_FREQ_MHZ = 50,
  parameter int BAUD = 115200,
  parameter int ADDR_WIDTH = 12
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rx,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [7:0]            mem_wdata,
  output logic                  cpu_halt,
  output logic                  rx_wait,
  output logic                  done,
  output logic                  err
);
  localparam int CPB = clks_per_bit(CLOCK_FREQ_MHZ, BAUD);
  logic [7:0] rx_data;
  logic rx_valid, rx_ferr;
  mk14_uart_rx #(.CPB(CPB)) u_rx (
    .clk(clk),
    .rst(rst),
    .rx(rx),
    .data(rx_data),
    .valid(rx_valid),
    .frame_err(rx_ferr)
  );
  loader_state_t st_q, st_d;
  logic [7:0] hi_q, hi_d, sum_q, sum_d, wdata_q, wdata_d;
  logic [ADDR_WIDTH-1:0] ptr_q, ptr_d, addr_q, addr_d;
  logic [8:0] cnt_q, cnt_d;
  logic we_q, we_d, halt_q, halt_d, wait_q, wait_d, done_q, done_d, err_q, err_d;
`ifdef MK14_LOADER_TIMEOUT_EN
  localparam int TL = TIMEOUT_BITS * CPB;
  localparam int TW = $clog2(TL + 1);
  logic [TW-1:0] tmo_q, tmo_d;
  logic tmo_hit;
`endif
  always_comb begin
    st_d = st_q;
    hi_d = hi_q;
    sum_d = sum_q;
    ptr_d = ptr_q;
    cnt_d = cnt_q;
    we_d = 1'b0;
    addr_d = addr_q;
    wdata_d = wdata_q;
    halt_d = halt_q;
    done_d = 1'b0;
    err_d = err_q;
    if (rx_ferr && st_q != S_IDLE) begin
      st_d = S_IDLE;
      halt_d = 1'b0;
      err_d = 1'b1;
    end else if (rx_valid) begin
      sum_d = sum_q + rx_data;
      case (st_q)
        S_IDLE: if (rx_data == SYNC_BYTE) begin
          st_d = S_AHI;
          halt_d = 1'b1;
          err_d = 1'b0;
          sum_d = '0;
        end
        S_AHI: begin
          hi_d = rx_data;
          st_d = S_ALO;
        end
        S_ALO: begin
          ptr_d = ADDR_WIDTH'({hi_q, rx_data});
          st_d = S_LEN;
        end
        S_LEN: begin
          cnt_d = {rx_data == 8'd0, rx_data};
          st_d = S_DATA;
        end
        S_DATA: begin
          we_d = 1'b1;
          addr_d = ptr_q;
          wdata_d = rx_data;
          ptr_d = ptr_q + ADDR_WIDTH'(1);
          cnt_d = cnt_q - 9'd1;
          st_d = (cnt_q == 9'd1) ? S_CSUM : S_DATA;
        end
        S_CSUM: begin
          st_d = S_IDLE;
          done_d = 1'b1;
          halt_d = 1'b0;
          err_d = sum_d != 8'd0;
        end
        default: st_d = S_IDLE;
      endcase
    end
`ifdef MK14_LOADER_TIMEOUT_EN
    tmo_hit = st_q != S_IDLE && !rx_valid && !rx_ferr && tmo_q == TW'(TL - 1);
    tmo_d = (st_q == S_IDLE || rx_valid || rx_ferr || tmo_hit) ? '0 : tmo_q + TW'(1);
    if (tmo_hit) begin
      st_d = S_IDLE;
      halt_d = 1'b0;
      err_d = 1'b1;
    end
`endif
    wait_d = !halt_d;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      st_q <= S_IDLE;
      hi_q <= '0;
      sum_q <= '0;
      ptr_q <= '0;
      cnt_q <= '0;
      we_q <= 1'b0;
      addr_q <= '0;
      wdata_q <= '0;
      halt_q <= 1'b0;
      wait_q <= 1'b1;
      done_q <= 1'b0;
      err_q <= 1'b0;
`ifdef MK14_LOADER_TIMEOUT_EN
      tmo_q <= '0;
`endif
    end else begin
      st_q <= st_d;
      hi_q <= hi_d;
      sum_q <= sum_d;
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
      we_q <= we_d;
      addr_q <= addr_d;
      wdata_q <= wdata_d;
      halt_q <= halt_d;
      wait_q <= wait_d;
      done_q <= done_d;
      err_q <= err_d;
`ifdef MK14_LOADER_TIMEOUT_EN
      tmo_q <= tmo_d;
`endif
    end
  end
  assign mem_we = we_q;
  assign mem_addr = addr_q;
  assign mem_wdata = wdata_q;
  assign cpu_halt = halt_q;
  assign rx_wait = wait_q;
  assign done = done_q;
  assign err = err_q;
endmodule

// File: tb/tb_mk14_rx_loader.sv
// tb_mk14_rx_loader: table-driven and random frame checks against a frame-level reference model
module tb_mk14_rx_loader;
  localparam int FREQ = 50;
  localparam int BAUD = 5_000_000;
  localparam int CPB = 10;
  localparam int AW = 12;
  logic clk = 1'b0, rst = 1'b1, rx = 1'b1;
  logic mem_we, cpu_halt, rx_wait, done, err;
  logic [AW-1:0] mem_addr;
  logic [7:0] mem_wdata;
  mk14_rx_loader #(.CLOCK_FREQ_MHZ(FREQ), .BAUD(BAUD), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst), .rx(rx), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .cpu_halt(cpu_halt), .rx_wait(rx_wait), .done(done), .err(err)
  );
  always #10 clk = ~clk;
  typedef struct packed {logic [AW-1:0] a; logic [7:0] d;} wr_t;
  typedef struct {logic [7:0] b[8]; int n; int bad; logic e_err; int e_done; int e_nwr;} vec_t;
  wr_t got[$], exp_q[$];
  logic [7:0] frm[$];
  int total = 0, bad = 0, done_cnt = 0, consec = 0;
  logic we_prev = 1'b0;
  always @(negedge clk) begin
    if (mem_we) got.push_back({mem_addr, mem_wdata});
    if (mem_we && we_prev) consec++;
    we_prev = mem_we;
    if (done) done_cnt++;
  end
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic send_bit(input logic b);
    @(negedge clk);
    rx = b;
    repeat (CPB - 1) @(negedge clk);
  endtask
  task automatic send_byte(input logic [7:0] v, input logic stop, input bit sync_chk);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(v[i]);
    @(negedge clk);
    rx = stop;
    if (sync_chk) chk("halt_before_sync", cpu_halt, 0);
    repeat (CPB - 1) @(negedge clk);
    if (sync_chk) begin
      chk("halt_after_sync", cpu_halt, 1);
      chk("wait_after_sync", rx_wait, 0);
      chk("err_clr_at_sync", err, 0);
    end
    if (!stop) begin
      @(negedge clk);
      rx = 1'b1;
    end
  endtask
  // Frame-level reference: which writes the bytes imply and how the frame ends.
  task automatic model(input int bad_idx, output logic e_err, output int e_done, output logic e_halt);
    int len, base, lim, s;
    exp_q.delete();
    len = (frm[3] == 8'd0) ? 256 : int'(frm[3]);
    base = (int'(frm[1]) * 256 + int'(frm[2])) % (1 << AW);
    lim = (bad_idx < 0) ? frm.size() : bad_idx;
    for (int i = 0; i < len; i++)
      if (4 + i < lim) exp_q.push_back({AW'((base + i) % (1 << AW)), frm[4 + i]});
    if (bad_idx < 0 && frm.size() >= len + 5) begin
      s = 0;
      for (int i = 1; i < len + 5; i++) s += int'(frm[i]);
      e_err = (s % 256) != 0;
      e_done = 1;
      e_halt = 1'b0;
    end else begin
      e_err = 1'b1;
      e_done = 0;
      e_halt = 1'b0;
    end
  endtask
  task automatic run_frame(input int bad_idx, input string tag);
    logic e_err, e_halt;
    int e_done;
    got.delete();
    done_cnt = 0;
    for (int i = 0; i < frm.size() && (bad_idx < 0 || i <= bad_idx); i++)
      send_byte(frm[i], i != bad_idx, i == 0);
    repeat (3 * CPB) @(negedge clk);
    model(bad_idx, e_err, e_done, e_halt);
    chk($sformatf("%s_nwr", tag), got.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got.size(); i++)
      chk($sformatf("%s_wr%0d", tag, i), got[i], exp_q[i]);
    chk($sformatf("%s_done", tag), done_cnt, e_done);
    chk($sformatf("%s_err", tag), err, e_err);
    chk($sformatf("%s_halt", tag), cpu_halt, e_halt);
    chk($sformatf("%s_wait", tag), rx_wait, !e_halt);
  endtask
  initial begin
    #4_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
  initial begin
    vec_t tbl[5];
    int len, s;
    tbl[0] = '{'{8'h55, 8'h0F, 8'h12, 8'h02, 8'hAA, 8'hBB, 8'h78, 8'h00}, 7, -1, 1'b0, 1, 2};
    tbl[1] = '{'{8'h55, 8'h0F, 8'hFF, 8'h02, 8'h11, 8'h22, 8'hBD, 8'h00}, 7, -1, 1'b0, 1, 2};
    tbl[2] = '{'{8'h55, 8'h00, 8'h10, 8'h01, 8'h42, 8'h00, 8'h00, 8'h00}, 6, -1, 1'b1, 1, 1};
    tbl[3] = '{'{8'h55, 8'h01, 8'h23, 8'h01, 8'h5A, 8'h81, 8'h00, 8'h00}, 6, -1, 1'b0, 1, 1};
    tbl[4] = '{'{8'h55, 8'h03, 8'h00, 8'h03, 8'h10, 8'h20, 8'h30, 8'h00}, 7, 5, 1'b1, 0, 1};
    repeat (5) @(negedge clk);
    chk("rst_we", mem_we, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_wdata", mem_wdata, 0);
    chk("rst_halt", cpu_halt, 0);
    chk("rst_wait", rx_wait, 1);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    rst = 1'b0;
    repeat (3 * CPB) @(negedge clk);
    send_byte(8'hA5, 1'b1, 1'b0);
    repeat (2 * CPB) @(negedge clk);
    chk("idle_nonsync_halt", cpu_halt, 0);
    for (int k = 0; k < 5; k++) begin
      frm.delete();
      for (int j = 0; j < tbl[k].n; j++) frm.push_back(tbl[k].b[j]);
      run_frame(tbl[k].bad, $sformatf("vec%0d", k));
      chk($sformatf("vec%0d_tbl_err", k), err, tbl[k].e_err);
      chk($sformatf("vec%0d_tbl_done", k), done_cnt, tbl[k].e_done);
      chk($sformatf("vec%0d_tbl_nwr", k), got.size(), tbl[k].e_nwr);
    end
    for (int k = 0; k < 6; k++) begin
      frm.delete();
      frm.push_back(8'h55);
      frm.push_back(8'($urandom));
      frm.push_back(8'($urandom));
      len = $urandom_range(1, 5);
      frm.push_back(8'(len));
      for (int j = 0; j < len; j++) frm.push_back(8'($urandom));
      s = 0;
      for (int j = 1; j < frm.size(); j++) s += int'(frm[j]);
      frm.push_back(($urandom_range(0, 1) == 1) ? 8'((256 - s % 256) % 256) : 8'($urandom));
      run_frame(-1, $sformatf("rnd%0d", k));
    end
    frm.delete();
    frm.push_back(8'h55);
    frm.push_back(8'h0F);
    frm.push_back(8'h80);
    frm.push_back(8'h00);
    s = 8'h0F + 8'h80;
    for (int j = 0; j < 256; j++) begin
      frm.push_back(8'(j) ^ 8'h5A);
      s += int'(8'(j) ^ 8'h5A);
    end
    frm.push_back(8'((256 - s % 256) % 256));
    run_frame(-1, "len0");
    got.delete();
    done_cnt = 0;
    send_byte(8'h55, 1'b1, 1'b1);
    send_byte(8'h01, 1'b1, 1'b0);
    send_byte(8'h00, 1'b1, 1'b0);
    repeat (25 * CPB) @(negedge clk);
`ifdef MK14_LOADER_TIMEOUT_EN
    chk("tmo_halt", cpu_halt, 0);
    chk("tmo_err", err, 1);
`else
    chk("tmo_halt", cpu_halt, 1);
    chk("tmo_err", err, 0);
`endif
    chk("tmo_done", done_cnt, 0);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_halt", cpu_halt, 0);
    chk("midrst_wait", rx_wait, 1);
    chk("midrst_err", err, 0);
    rst = 1'b0;
    send_byte(8'h33, 1'b1, 1'b0);
    repeat (3 * CPB) @(negedge clk);
    chk("midrst_nwr", got.size(), 0);
    chk("midrst_halt_after", cpu_halt, 0);
    chk("no_consec_we", consec, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
